// File: rtl/torreta_disparo.sv
// Firing-mechanism responder: arm/fire/reload handshakes, actuator drives
// and magazine round tracking for the turret control unit.
module torreta_disparo #(
    parameter int T_ARMAR    = 25_000_000,
    parameter int T_GATILHO  = 5_000_000,
    parameter int T_RECARGA  = 50_000_000,
    parameter int CAPACIDADE = 6,
    parameter int W_MUN      = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             armar_disparo,
    input  logic             disparar,
    input  logic             recarregar_disparo,
    input  logic             remuniciar,
    output logic             disparo_pronto,
    output logic             fim_disparo,
    output logic             disparo_carregado,
    output logic             municao_carregada,
    output logic             trava,
    output logic             gatilho,
    output logic             motor_recarga,
    output logic [W_MUN-1:0] municao,
    output logic [3:0]       db_estado
);

    typedef enum logic [3:0] {
        REPOUSO      = 4'd0,
        ARMANDO      = 4'd1,
        ARMADO       = 4'd2,
        DISPARANDO   = 4'd3,
        DISPARADO    = 4'd4,
        RECARREGANDO = 4'd5,
        CARREGADO    = 4'd6
    } estado_t;

    localparam logic [31:0] FIM_ARMAR   = 32'(T_ARMAR - 1);
    localparam logic [31:0] FIM_GATILHO = 32'(T_GATILHO - 1);
    localparam logic [31:0] FIM_RECARGA = 32'(T_RECARGA - 1);
    localparam logic [W_MUN-1:0] CHEIO  = W_MUN'(CAPACIDADE);

    estado_t          estado_q, estado_d;
    logic [31:0]      timer_q, timer_d;
    logic [W_MUN-1:0] municao_q, municao_d;
    logic             tem_municao;
    logic             temporizado;

    assign tem_municao = (municao_q != '0);
    assign temporizado = (estado_q == ARMANDO) ||
                         (estado_q == DISPARANDO) ||
                         (estado_q == RECARREGANDO);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= REPOUSO;
            timer_q   <= '0;
            municao_q <= '0;
        end else begin
            estado_q  <= estado_d;
            timer_q   <= timer_d;
            municao_q <= municao_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        municao_d = municao_q;
        case (estado_q)
            REPOUSO: begin
                if (remuniciar) begin
                    municao_d = CHEIO;
                end else if (armar_disparo && tem_municao) begin
                    estado_d = ARMANDO;
                end
            end
            ARMANDO: begin
                if (!armar_disparo) begin
                    estado_d = REPOUSO;
                end else if (timer_q == FIM_ARMAR) begin
                    estado_d = ARMADO;
                end
            end
            ARMADO: begin
                if (disparar) begin
                    estado_d = DISPARANDO;
                end else if (!armar_disparo) begin
                    estado_d = REPOUSO;
                end
            end
            DISPARANDO: begin
                if (timer_q == FIM_GATILHO) begin
                    estado_d = DISPARADO;
                    if (tem_municao) begin
                        municao_d = municao_q - 1'b1;
                    end
                end
            end
            DISPARADO: begin
                if (recarregar_disparo) begin
                    estado_d = RECARREGANDO;
                end
            end
            RECARREGANDO: begin
                // an empty magazine still completes the handshake, motor idle
                if (!tem_municao || (timer_q == FIM_RECARGA)) begin
                    estado_d = CARREGADO;
                end
            end
            CARREGADO: begin
                if (!recarregar_disparo) begin
                    estado_d = REPOUSO;
                end
            end
            default: begin
                estado_d = REPOUSO;
            end
        endcase
    end

    always_comb begin
        timer_d = '0;
        if ((estado_d == estado_q) && temporizado) begin
            timer_d = timer_q + 32'd1;
        end
    end

    assign trava = (estado_q == ARMANDO) ||
                   (estado_q == ARMADO) ||
                   (estado_q == DISPARANDO);
    assign disparo_pronto    = (estado_q == ARMADO);
    assign gatilho           = (estado_q == DISPARANDO);
    assign fim_disparo       = (estado_q == DISPARADO);
    assign motor_recarga     = (estado_q == RECARREGANDO) && tem_municao;
    assign disparo_carregado = (estado_q == CARREGADO);
    assign municao_carregada = tem_municao;
    assign municao           = municao_q;
    assign db_estado         = estado_q;

endmodule

// File: tb/tb_torreta_disparo.sv
// Scoreboard bench for torreta_disparo: stimulus queues expected
// handshake events, a negedge monitor pops and compares them.
module tb_torreta_disparo;

    localparam int K_PRONTO = 0;
    localparam int K_GAT    = 1;
    localparam int K_FIM    = 2;
    localparam int K_MOT    = 3;
    localparam int K_CARR   = 4;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       armar_disparo;
    logic       disparar;
    logic       recarregar_disparo;
    logic       remuniciar;
    logic       disparo_pronto;
    logic       fim_disparo;
    logic       disparo_carregado;
    logic       municao_carregada;
    logic       trava;
    logic       gatilho;
    logic       motor_recarga;
    logic [2:0] municao;
    logic [3:0] db_estado;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;
    int   n;

    torreta_disparo #(
        .T_ARMAR   (4),
        .T_GATILHO (3),
        .T_RECARGA (5),
        .CAPACIDADE(2),
        .W_MUN     (3)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .armar_disparo     (armar_disparo),
        .disparar          (disparar),
        .recarregar_disparo(recarregar_disparo),
        .remuniciar        (remuniciar),
        .disparo_pronto    (disparo_pronto),
        .fim_disparo       (fim_disparo),
        .disparo_carregado (disparo_carregado),
        .municao_carregada (municao_carregada),
        .trava             (trava),
        .gatilho           (gatilho),
        .motor_recarga     (motor_recarga),
        .municao           (municao),
        .db_estado         (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic report(input int kind, input int val);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_event: kind %0d val %0d, expected none",
                     kind, val);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            check("event_value", val, e.val);
        end
    endtask

    // monitor: turns output edges into events carrying a measured value
    int arm_cnt = 0;
    int gat_cnt = 0;
    int mot_cnt = 0;
    logic p_pronto = 0, p_gat = 0, p_fim = 0, p_mot = 0, p_carr = 0;

    always @(negedge clock) begin
        if (reset) begin
            arm_cnt  = 0;
            gat_cnt  = 0;
            mot_cnt  = 0;
            p_pronto = 0;
            p_gat    = 0;
            p_fim    = 0;
            p_mot    = 0;
            p_carr   = 0;
        end else begin
            if (disparo_pronto && !p_pronto) report(K_PRONTO, arm_cnt);
            if (!gatilho && p_gat) report(K_GAT, gat_cnt);
            if (fim_disparo && !p_fim) report(K_FIM, int'(municao));
            if (!motor_recarga && p_mot) report(K_MOT, mot_cnt);
            if (disparo_carregado && !p_carr)
                report(K_CARR, int'(municao_carregada));
            arm_cnt  = (trava && !disparo_pronto) ? arm_cnt + 1 : 0;
            gat_cnt  = gatilho ? gat_cnt + 1 : 0;
            mot_cnt  = motor_recarga ? mot_cnt + 1 : 0;
            p_pronto = disparo_pronto;
            p_gat    = gatilho;
            p_fim    = fim_disparo;
            p_mot    = motor_recarga;
            p_carr   = disparo_carregado;
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_for(input int sel, input int budget, output int cnt);
        logic s;
        cnt = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clock);
            case (sel)
                0:       s = disparo_pronto;
                1:       s = fim_disparo;
                2:       s = disparo_carregado;
                default: s = gatilho;
            endcase
            if (s) begin
                cnt = i;
                break;
            end
        end
        if (cnt < 0) begin
            tests++;
            failed++;
            $display("FAIL timeout: signal %0d not seen, expected within %0d",
                     sel, budget);
        end
    endtask

    initial begin
        reset              = 1'b1;
        armar_disparo      = 1'b0;
        disparar           = 1'b0;
        recarregar_disparo = 1'b0;
        remuniciar         = 1'b0;
        repeat (2) tick();
        check("rst_municao", int'(municao), 0);
        check("rst_estado", int'(db_estado), 0);
        check("rst_outputs", int'({disparo_pronto, fim_disparo,
              disparo_carregado, municao_carregada, trava, gatilho,
              motor_recarga}), 0);
        reset = 1'b0;

        // T1: arm with empty magazine is ignored
        armar_disparo = 1'b1;
        repeat (6) tick();
        check("t1_estado", int'(db_estado), 0);
        check("t1_pronto", int'(disparo_pronto), 0);
        armar_disparo = 1'b0;
        tick();

        // T2: full cycle
        remuniciar = 1'b1;
        tick();
        remuniciar = 1'b0;
        check("t2_municao", int'(municao), 2);
        check("t2_carregada", int'(municao_carregada), 1);
        push(K_PRONTO, 4);
        push(K_GAT, 3);
        push(K_FIM, 1);
        push(K_MOT, 5);
        push(K_CARR, 1);
        armar_disparo = 1'b1;
        wait_for(0, 20, n);
        check("t2_arm_latency", n, 5);
        disparar = 1'b1;
        wait_for(1, 20, n);
        check("t2_fire_latency", n, 4);
        disparar      = 1'b0;
        armar_disparo = 1'b0;
        recarregar_disparo = 1'b1;
        wait_for(2, 20, n);
        check("t2_reload_latency", n, 6);
        recarregar_disparo = 1'b0;
        tick();
        check("t2_back_repouso", int'(db_estado), 0);

        // T3: second shot empties the magazine
        push(K_PRONTO, 4);
        push(K_GAT, 3);
        push(K_FIM, 0);
        push(K_CARR, 0);
        armar_disparo = 1'b1;
        wait_for(0, 20, n);
        disparar = 1'b1;
        wait_for(1, 20, n);
        disparar      = 1'b0;
        armar_disparo = 1'b0;
        check("t3_municao", int'(municao), 0);
        check("t3_carregada", int'(municao_carregada), 0);
        recarregar_disparo = 1'b1;
        wait_for(2, 20, n);
        check("t3_reload_latency", n, 2);
        check("t3_motor", int'(motor_recarga), 0);
        recarregar_disparo = 1'b0;
        tick();
        armar_disparo = 1'b1;
        repeat (6) tick();
        check("t3_rearm_estado", int'(db_estado), 0);
        check("t3_rearm_trava", int'(trava), 0);
        armar_disparo = 1'b0;
        tick();

        // T5: refill and arm on the same cycle
        remuniciar    = 1'b1;
        armar_disparo = 1'b1;
        tick();
        check("t5_municao", int'(municao), 2);
        check("t5_estado0", int'(db_estado), 0);
        remuniciar = 1'b0;
        tick();
        check("t5_armando", int'(db_estado), 1);
        check("t5_trava", int'(trava), 1);

        // T4: abort in ARMANDO cycle 2
        tick();
        armar_disparo = 1'b0;
        tick();
        check("t4_estado", int'(db_estado), 0);
        check("t4_trava", int'(trava), 0);
        check("t4_municao", int'(municao), 2);

        // T6: reset mid-shot
        push(K_PRONTO, 4);
        armar_disparo = 1'b1;
        wait_for(0, 20, n);
        disparar = 1'b1;
        wait_for(3, 20, n);
        check("t6_gat_latency", n, 1);
        tick();
        reset         = 1'b1;
        disparar      = 1'b0;
        armar_disparo = 1'b0;
        tick();
        check("t6_gatilho", int'(gatilho), 0);
        check("t6_municao", int'(municao), 0);
        check("t6_estado", int'(db_estado), 0);
        check("t6_trava", int'(trava), 0);
        reset = 1'b0;
        tick();
        check("t6_idle", int'(db_estado), 0);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
